// File: rtl/prbs7_checker.sv
// PRBS7 (x^7+x^6+1) serial checker: seeds from the incoming stream, locks after a run
// of correct predictions, then counts errors against a free-running local predictor.
module prbs7_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4,
    parameter int UNLOCK_WIN = 64,
    parameter int CNT_W      = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    input  logic             V,
    input  logic             CLR,
    output logic             LOCK,
    output logic             ERR,
    output logic [CNT_W-1:0] ERRCNT
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(UNLOCK_WIN + 1);
    localparam int EW = $clog2(UNLOCK_ERR + 1);

    localparam logic [MW-1:0] LAST_MATCH = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] LAST_WIN   = WW'(UNLOCK_WIN - 1);
    localparam logic [EW-1:0] ERR_LIMIT  = EW'(UNLOCK_ERR);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [6:0]       r_s;
    logic [2:0]       r_seed;
    logic [MW-1:0]    r_match;
    logic [WW-1:0]    r_win;
    logic [EW-1:0]    r_werr;
    logic             r_lock;
    logic             r_err;
    logic [CNT_W-1:0] r_errcnt;

    logic             w_pred;
    logic             w_miss;
    logic             w_s_nz;
    logic             w_win_last;
    logic [EW-1:0]    w_werr_next;
    logic             w_unlock;
    logic             w_err_ev;
    logic             w_cnt_sat;

    assign w_pred      = r_s[6] ^ r_s[5];
    assign w_miss      = D ^ w_pred;
    assign w_s_nz      = |r_s;
    assign w_win_last  = (r_win == LAST_WIN);
    assign w_werr_next = r_werr + EW'(1);
    assign w_unlock    = w_miss && (w_werr_next == ERR_LIMIT);
    assign w_err_ev    = V && (r_state == LOCKED) && w_miss;
    assign w_cnt_sat   = &r_errcnt;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state  <= SEED;
            r_s      <= '0;
            r_seed   <= '0;
            r_match  <= '0;
            r_win    <= '0;
            r_werr   <= '0;
            r_lock   <= 1'b0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
        end else begin
            r_err <= w_err_ev;

            // Clear beats a coincident error increment.
            if (CLR) begin
                r_errcnt <= '0;
            end else if (w_err_ev && !w_cnt_sat) begin
                r_errcnt <= r_errcnt + CNT_W'(1);
            end

            if (V) begin
                case (r_state)
                    SEED: begin
                        r_s <= {r_s[5:0], D};
                        if (r_seed == 3'd6) begin
                            r_seed  <= '0;
                            r_match <= '0;
                            r_state <= SEARCH;
                        end else begin
                            r_seed <= r_seed + 3'd1;
                        end
                    end
                    SEARCH: begin
                        r_s <= {r_s[5:0], D};
                        // An all-zero history predicts zero forever, so it never counts as a match.
                        if (!w_miss && w_s_nz) begin
                            if (r_match == LAST_MATCH) begin
                                r_match <= '0;
                                r_win   <= '0;
                                r_werr  <= '0;
                                r_lock  <= 1'b1;
                                r_state <= LOCKED;
                            end else begin
                                r_match <= r_match + MW'(1);
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    LOCKED: begin
                        r_s <= {r_s[5:0], w_pred};
                        if (w_unlock) begin
                            r_state <= SEED;
                            r_lock  <= 1'b0;
                            r_seed  <= '0;
                            r_match <= '0;
                            r_win   <= '0;
                            r_werr  <= '0;
                        end else if (w_win_last) begin
                            r_win  <= '0;
                            r_werr <= '0;
                        end else begin
                            r_win <= r_win + WW'(1);
                            if (w_miss) begin
                                r_werr <= w_werr_next;
                            end
                        end
                    end
                    default: r_state <= SEED;
                endcase
            end
        end
    end

    assign LOCK   = r_lock;
    assign ERR    = r_err;
    assign ERRCNT = r_errcnt;

endmodule
